// File: rtl/mig_app_responder.sv
// MIG 7-series app-interface responder: queues commands and write data,
// stores bursts in an internal RAM and returns read data in order.
// Ports:
//   ui_clk, ui_clk_sync_rst        clock, async active-high reset
//   init_calib_complete            calibration-done emulation
//   app_addr/app_cmd/app_en/app_rdy            command channel
//   app_wdf_data/mask/wren/end/app_wdf_rdy     write-data channel
//   app_rd_data/valid/end          read-data return (no backpressure)
//   err_flag                       sticky protocol error
module mig_app_responder #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int MEM_AW       = 8,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int BP_EN        = 0
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  output logic                init_calib_complete,
  input  logic [ADDR_W-1:0]   app_addr,
  input  logic [2:0]          app_cmd,
  input  logic                app_en,
  output logic                app_rdy,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                err_flag
);

  localparam int MW = DATA_W / 8;
  localparam int CW = $clog2(CALIB_CYCLES + 1);

  logic          calib_q;
  logic [CW-1:0] cal_cnt_q;
  logic [15:0]   lfsr_q;
  logic          lfsr_fb;
  logic          bp;

  logic [2:0]        cq_cmd [4];
  logic [MEM_AW-1:0] cq_idx [4];
  logic [1:0]        cq_wp_q, cq_rp_q;
  logic [2:0]        cq_cnt_q, cq_cnt_d;

  logic [DATA_W-1:0] wq_data [4];
  logic [MW-1:0]     wq_mask [4];
  logic [1:0]        wq_wp_q, wq_rp_q;
  logic [2:0]        wq_cnt_q, wq_cnt_d;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  logic              pv_q [RD_LATENCY];
  logic [DATA_W-1:0] pd_q [RD_LATENCY];
  logic              rv_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q, err_d;

  logic              cmd_push, wdf_push;
  logic              cmd_pop, wdf_pop;
  logic              rd_issue, bad_cmd;
  logic              head_vld;
  logic [2:0]        head_cmd;
  logic [MEM_AW-1:0] head_idx;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{app_addr[2:0], app_addr[ADDR_W-1:MEM_AW+3]};

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign bp      = (BP_EN != 0) && (lfsr_q[1:0] == 2'b00);

  // Ready uses the pre-pop counts: a full FIFO stays not-ready
  // even in a cycle where its head retires.
  assign app_rdy     = calib_q & (cq_cnt_q != 3'd4) & ~bp;
  assign app_wdf_rdy = calib_q & (wq_cnt_q != 3'd4) & ~bp;

  assign cmd_push = app_en & app_rdy;
  assign wdf_push = app_wdf_wren & app_wdf_rdy;

  assign head_vld = (cq_cnt_q != 3'd0);
  assign head_cmd = cq_cmd[cq_rp_q];
  assign head_idx = cq_idx[cq_rp_q];

  // Head retirement: writes wait for a data beat, reads and
  // unknown commands retire immediately.
  always_comb begin
    cmd_pop  = 1'b0;
    wdf_pop  = 1'b0;
    rd_issue = 1'b0;
    bad_cmd  = 1'b0;
    if (head_vld) begin
      unique case (head_cmd)
        3'b000: begin
          if (wq_cnt_q != 3'd0) begin
            cmd_pop = 1'b1;
            wdf_pop = 1'b1;
          end
        end
        3'b001: begin
          cmd_pop  = 1'b1;
          rd_issue = 1'b1;
        end
        default: begin
          cmd_pop = 1'b1;
          bad_cmd = 1'b1;
        end
      endcase
    end
  end

  assign cq_cnt_d = cq_cnt_q + {2'b0, cmd_push} - {2'b0, cmd_pop};
  assign wq_cnt_d = wq_cnt_q + {2'b0, wdf_push} - {2'b0, wdf_pop};
  assign err_d    = err_q | bad_cmd | (wdf_push & ~app_wdf_end);

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      calib_q   <= 1'b0;
      cal_cnt_q <= '0;
      lfsr_q    <= 16'hACE1;
      cq_wp_q   <= '0;
      cq_rp_q   <= '0;
      cq_cnt_q  <= '0;
      wq_wp_q   <= '0;
      wq_rp_q   <= '0;
      wq_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (!calib_q) begin
        cal_cnt_q <= cal_cnt_q + 1'b1;
        if (cal_cnt_q == CW'(CALIB_CYCLES - 1))
          calib_q <= 1'b1;
      end
      if (calib_q)
        lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      if (cmd_push) cq_wp_q <= cq_wp_q + 1'b1;
      if (cmd_pop)  cq_rp_q <= cq_rp_q + 1'b1;
      if (wdf_push) wq_wp_q <= wq_wp_q + 1'b1;
      if (wdf_pop)  wq_rp_q <= wq_rp_q + 1'b1;
      cq_cnt_q <= cq_cnt_d;
      wq_cnt_q <= wq_cnt_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage is qualified by the reset-cleared pointers.
  always_ff @(posedge ui_clk) begin
    if (cmd_push) begin
      cq_cmd[cq_wp_q] <= app_cmd;
      cq_idx[cq_wp_q] <= app_addr[MEM_AW+2:3];
    end
    if (wdf_push) begin
      wq_data[wq_wp_q] <= app_wdf_data;
      wq_mask[wq_wp_q] <= app_wdf_mask;
    end
  end

  // RAM survives reset; mask bit 1 leaves the byte untouched.
  always_ff @(posedge ui_clk) begin
    if (wdf_pop) begin
      for (int b = 0; b < MW; b++) begin
        if (!wq_mask[wq_rp_q][b])
          mem[head_idx][b*8 +: 8] <= wq_data[wq_rp_q][b*8 +: 8];
      end
    end
  end

  // Read pipeline plus an output register: valid appears
  // RD_LATENCY+1 cycles after the command handshake.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= '0;
      end
      rv_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      pv_q[0] <= rd_issue;
      if (rd_issue)
        pd_q[0] <= mem[head_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      rv_q <= pv_q[RD_LATENCY-1];
      if (pv_q[RD_LATENCY-1])
        rdata_q <= pd_q[RD_LATENCY-1];
    end
  end

  assign init_calib_complete = calib_q;
  assign app_rd_data         = rdata_q;
  assign app_rd_data_valid   = rv_q;
  assign app_rd_data_end     = rv_q;
  assign err_flag            = err_q;

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: calibration, ordering,
// latency, masking, stalls, errors, backpressure and mid-run reset.
module tb_mig_app_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [27:0]  a_addr = '0, b_addr = '0;
  logic [2:0]   a_cmd = '0, b_cmd = '0;
  logic         a_en = 0, b_en = 0;
  logic [127:0] a_wdata = '0, b_wdata = '0;
  logic [15:0]  a_mask = '0, b_mask = '0;
  logic         a_wren = 0, b_wren = 0;
  logic         a_end = 0, b_end = 0;
  logic         a_rdy, a_wrdy, a_valid, a_rend, a_err, a_calib;
  logic         b_rdy, b_wrdy, b_valid, b_rend, b_err, b_calib;
  logic [127:0] a_rdata, b_rdata;

  int n_chk = 0;
  int n_err = 0;
  int vcount = 0;
  logic [127:0] bq [$];

  mig_app_responder #(
    .RD_LATENCY(4), .CALIB_CYCLES(64), .BP_EN(0)
  ) dut_a (
    .ui_clk(clk), .ui_clk_sync_rst(rst),
    .init_calib_complete(a_calib),
    .app_addr(a_addr), .app_cmd(a_cmd), .app_en(a_en),
    .app_rdy(a_rdy),
    .app_wdf_data(a_wdata), .app_wdf_mask(a_mask),
    .app_wdf_wren(a_wren), .app_wdf_end(a_end),
    .app_wdf_rdy(a_wrdy),
    .app_rd_data(a_rdata), .app_rd_data_valid(a_valid),
    .app_rd_data_end(a_rend), .err_flag(a_err)
  );

  mig_app_responder #(
    .RD_LATENCY(1), .CALIB_CYCLES(8), .BP_EN(1)
  ) dut_b (
    .ui_clk(clk), .ui_clk_sync_rst(rst),
    .init_calib_complete(b_calib),
    .app_addr(b_addr), .app_cmd(b_cmd), .app_en(b_en),
    .app_rdy(b_rdy),
    .app_wdf_data(b_wdata), .app_wdf_mask(b_mask),
    .app_wdf_wren(b_wren), .app_wdf_end(b_end),
    .app_wdf_rdy(b_wrdy),
    .app_rd_data(b_rdata), .app_rd_data_valid(b_valid),
    .app_rd_data_end(b_rend), .err_flag(b_err)
  );

  always @(posedge clk) if (a_valid) vcount++;
  always @(posedge clk) if (b_valid) bq.push_back(b_rdata);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_send(input bit do_c, input logic [2:0] c,
                        input logic [27:0] ad, input bit do_w,
                        input logic [127:0] d, input logic [15:0] m,
                        input logic e);
    int n;
    bit cp, wp, cok, wok;
    n = 0; cp = do_c; wp = do_w;
    a_en = do_c; a_cmd = c; a_addr = ad;
    a_wren = do_w; a_wdata = d; a_mask = m; a_end = e;
    while ((cp || wp) && n < 200) begin
      cok = cp && a_rdy;
      wok = wp && a_wrdy;
      tick();
      n++;
      if (cok) begin cp = 0; a_en = 0; end
      if (wok) begin wp = 0; a_wren = 0; end
    end
    a_en = 0; a_wren = 0;
    chk("a_handshake_timeout", {126'b0, cp, wp}, 0);
  endtask

  task automatic b_send(input bit do_c, input logic [2:0] c,
                        input logic [27:0] ad, input bit do_w,
                        input logic [127:0] d);
    int n;
    bit cp, wp, cok, wok;
    n = 0; cp = do_c; wp = do_w;
    b_en = do_c; b_cmd = c; b_addr = ad;
    b_wren = do_w; b_wdata = d; b_mask = '0; b_end = 1;
    while ((cp || wp) && n < 200) begin
      cok = cp && b_rdy;
      wok = wp && b_wrdy;
      tick();
      n++;
      if (cok) begin cp = 0; b_en = 0; end
      if (wok) begin wp = 0; b_wren = 0; end
    end
    b_en = 0; b_wren = 0;
    chk("b_handshake_timeout", {126'b0, cp, wp}, 0);
  endtask

  task automatic a_wait_rd(input string tag, input logic [127:0] exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!a_valid && n < 50);
    chk({tag, "_valid"}, a_valid, 1);
    chk(tag, a_rdata, exp);
  endtask

  localparam logic [127:0] D1 =
    128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0001_AAAA_0001_AAAA_0001;
  localparam logic [127:0] DB = 128'hBBBB_0002_BBBB_0002_BBBB_0002_BBBB_0002;
  localparam logic [127:0] DC = 128'hCCCC_0003_CCCC_0003_CCCC_0003_CCCC_0003;
  localparam logic [127:0] DZ = 128'h5A5A_5A5A_0000_FFFF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] D4 = 128'hDDDD_0004_4444_DDDD_0004_4444_DDDD_0004;
  localparam logic [127:0] D5 = 128'h5555_0005_F0F0_0F0F_5555_0005_F0F0_0F0F;
  localparam logic [127:0] D6 = 128'h6666_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] MSKD = {{120{1'b1}}, 8'h00};

  initial begin
    int bad, vc0, lo, hi, mis, n;
    logic [127:0] exp_b;

    // Reset and calibration
    repeat (3) tick();
    chk("rst_calib", a_calib, 0);
    chk("rst_rdy", a_rdy, 0);
    chk("rst_wrdy", a_wrdy, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_rdata, 0);
    chk("rst_err", a_err, 0);
    rst = 0;
    bad = 0;
    for (int k = 1; k <= 63; k++) begin
      tick();
      if (a_calib || a_rdy || a_wrdy) bad++;
    end
    chk("calib_low_63", bad, 0);
    tick();
    chk("calib_high_64", a_calib, 1);
    chk("rdy_high_64", a_rdy, 1);
    chk("wrdy_high_64", a_wrdy, 1);

    // Single write then read, exact latency
    a_send(1, 3'b000, 28'h8, 1, D1, 16'h0, 1);
    a_send(1, 3'b001, 28'h8, 0, '0, 16'h0, 1);
    bad = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (a_valid) bad++;
    end
    chk("t2_early_valid", bad, 0);
    tick();
    chk("t2_valid", a_valid, 1);
    chk("t2_end", a_rend, 1);
    chk("t2_data", a_rdata, D1);
    tick();
    chk("t2_valid_1cyc", a_valid, 0);
    chk("t2_data_hold", a_rdata, D1);

    // Data ahead of commands, wdf fill boundary
    a_send(0, 3'b000, 28'h0, 1, DA, 16'h0, 1);
    a_send(0, 3'b000, 28'h0, 1, DB, 16'h0, 1);
    a_send(0, 3'b000, 28'h0, 1, DC, 16'h0, 1);
    chk("t3_wrdy_3beats", a_wrdy, 1);
    a_send(0, 3'b000, 28'h0, 1, DZ, 16'h0, 1);
    chk("t3_wrdy_4beats", a_wrdy, 0);
    a_send(1, 3'b000, 28'h10, 0, '0, 16'h0, 1);
    a_send(1, 3'b000, 28'h18, 0, '0, 16'h0, 1);
    a_send(1, 3'b000, 28'h20, 0, '0, 16'h0, 1);
    a_send(1, 3'b000, 28'h48, 0, '0, 16'h0, 1);
    a_send(1, 3'b001, 28'h10, 0, '0, 16'h0, 1);
    a_send(1, 3'b001, 28'h18, 0, '0, 16'h0, 1);
    a_send(1, 3'b001, 28'h20, 0, '0, 16'h0, 1);
    a_wait_rd("t3_rd0", DA);
    a_wait_rd("t3_rd1", DB);
    a_wait_rd("t3_rd2", DC);

    // Write with no data blocks reads behind it
    a_send(1, 3'b000, 28'h28, 0, '0, 16'h0, 1);
    vc0 = vcount;
    a_send(1, 3'b001, 28'h28, 0, '0, 16'h0, 1);
    a_send(1, 3'b001, 28'h10, 0, '0, 16'h0, 1);
    a_send(1, 3'b001, 28'h18, 0, '0, 16'h0, 1);
    chk("t4_rdy_full", a_rdy, 0);
    repeat (8) tick();
    chk("t4_rdy_still_full", a_rdy, 0);
    chk("t4_no_valid", vcount - vc0, 0);
    a_send(1, 3'b001, 28'h20, 1, D4, 16'h0, 1);
    a_wait_rd("t4_rd0", D4);
    a_wait_rd("t4_rd1", DA);
    a_wait_rd("t4_rd2", DB);
    a_wait_rd("t4_rd3", DC);

    // Byte mask and address wrap
    a_send(1, 3'b000, 28'h30, 1, ONES, 16'h0, 1);
    a_send(1, 3'b000, 28'h30, 1, '0, 16'hFFFE, 1);
    a_send(1, 3'b001, 28'h30, 0, '0, 16'h0, 1);
    a_wait_rd("t5_mask", MSKD);
    a_send(1, 3'b000, 28'h80F, 1, D5, 16'h0, 1);
    a_send(1, 3'b001, 28'h8, 0, '0, 16'h0, 1);
    a_wait_rd("t5_wrap", D5);

    // Unknown command
    chk("t6_err_before", a_err, 0);
    a_send(1, 3'b111, 28'h0, 0, '0, 16'h0, 1);
    tick();
    chk("t6_err_set", a_err, 1);
    a_send(1, 3'b001, 28'h30, 0, '0, 16'h0, 1);
    a_wait_rd("t6_rd_after_bad", MSKD);
    chk("t6_err_sticky", a_err, 1);

    // Reset with reads in flight
    a_send(1, 3'b001, 28'h8, 0, '0, 16'h0, 1);
    a_send(1, 3'b001, 28'h10, 0, '0, 16'h0, 1);
    a_send(1, 3'b001, 28'h18, 0, '0, 16'h0, 1);
    vc0 = vcount;
    rst = 1;
    tick();
    chk("mrst_calib", a_calib, 0);
    chk("mrst_rdy", a_rdy, 0);
    chk("mrst_wrdy", a_wrdy, 0);
    chk("mrst_valid", a_valid, 0);
    chk("mrst_data", a_rdata, 0);
    chk("mrst_err", a_err, 0);
    repeat (3) tick();
    rst = 0;
    repeat (10) tick();
    chk("mrst_no_valid", vcount - vc0, 0);
    n = 0;
    while (!a_calib && n < 100) begin tick(); n++; end
    chk("mrst_recalib", a_calib, 1);

    // Beat without wdf_end is stored but flagged
    chk("t7_err_clear", a_err, 0);
    a_send(1, 3'b000, 28'h50, 1, D6, 16'h0, 0);
    tick();
    chk("t7_err_noend", a_err, 1);
    a_send(1, 3'b001, 28'h50, 0, '0, 16'h0, 1);
    a_wait_rd("t7_rd", D6);
    vc0 = vcount;
    repeat (10) tick();
    chk("t7_single_pulse", vcount - vc0, 1);

    // Backpressure instance: idle ready pattern
    lo = 0; hi = 0; mis = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (b_rdy) hi++; else lo++;
      if (b_rdy !== b_wrdy) mis++;
    end
    chk("bp_low_seen", lo > 0, 1);
    chk("bp_high_seen", hi > 0, 1);
    chk("bp_rdy_match", mis, 0);

    // Backpressure instance: 10 writes, 10 reads
    for (int i = 0; i < 10; i++) begin
      exp_b = {4{32'hDEAD_0000 ^ (32'(i) * 32'h0101_0101)}};
      b_send(1, 3'b000, 28'(i * 8), 1, exp_b);
    end
    for (int i = 0; i < 10; i++)
      b_send(1, 3'b001, 28'(i * 8), 0, '0);
    n = 0;
    while (bq.size() < 10 && n < 200) begin tick(); n++; end
    chk("bp_rd_count", bq.size(), 10);
    for (int i = 0; i < 10; i++) begin
      exp_b = {4{32'hDEAD_0000 ^ (32'(i) * 32'h0101_0101)}};
      if (i < bq.size())
        chk($sformatf("bp_rd%0d", i), bq[i], exp_b);
    end
    chk("bp_err", b_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mig_app_responder.md
Name: mig_app_responder

Overview:
Synthesizable responder for the MIG 7-series user (app) interface. It stands in for mig_7series_0 so that ddr_rw and later frame-buffer masters can be simulated and hardware-looped without DDR3 pins. It accepts app commands and write data, stores them in an internal RAM, and returns read data with the MIG handshake and in-order semantics. It also produces init_calib_complete, app_rdy and app_wdf_rdy with optional pseudo-random backpressure.

Parameters:
ADDR_W, 28, app_addr width.
DATA_W, 128, app data width (4:1 mode, x16 DDR3, BL8).
MEM_AW, 8, log2 of RAM depth in DATA_W words.
RD_LATENCY, 4, cycles from read issue to app_rd_data_valid (minimum 1).
CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.
BP_EN, 0, 1 enables LFSR backpressure on app_rdy and app_wdf_rdy.

Ports:
ui_clk  in  1  clock; all logic on its rising edge
ui_clk_sync_rst  in  1  reset, asynchronous, active-high
init_calib_complete  out  1  calibration-done emulation
app_addr  in  ADDR_W  burst address
app_cmd  in  3  000 = write, 001 = read
app_en  in  1  command valid
app_rdy  out  1  command ready
app_wdf_data  in  DATA_W  write data
app_wdf_mask  in  DATA_W/8  byte mask, 1 = byte not written
app_wdf_wren  in  1  write data valid
app_wdf_end  in  1  last beat of burst
app_wdf_rdy  out  1  write data ready
app_rd_data  out  DATA_W  read data
app_rd_data_valid  out  1  read data valid
app_rd_data_end  out  1  equals app_rd_data_valid
err_flag  out  1  sticky protocol error

Behaviour:
- Reset is asynchronous. It clears all outputs to 0, the calibration counter, both FIFOs, the read pipeline, err_flag, and seeds the LFSR to 16'hACE1. RAM contents are not cleared.
- Calibration: a counter runs from reset release. init_calib_complete goes to 1 in the cycle after CALIB_CYCLES edges and stays 1 until reset.
- Command FIFO: depth 4, holds {cmd, addr}. A command is accepted when app_en & app_rdy.
  - app_rdy = init_calib_complete & cmd FIFO not full & ~bp.
  - app_rdy is registered-free combinational from state only. It never depends on app_en.
- Write-data FIFO: depth 4, holds {data, mask}. A beat is accepted when app_wdf_wren & app_wdf_rdy.
  - app_wdf_rdy = init_calib_complete & wdf FIFO not full & ~bp.
  - Data may arrive before, with, or after its command; up to 4 beats ahead.
- Word index = app_addr[MEM_AW+2:3]. app_addr[2:0] and the upper bits are ignored, so addresses wrap modulo 2^MEM_AW words.
- Execution is strictly in order, at most one command retired per cycle, from the cmd FIFO head.
  - Write at head: retires only when the wdf FIFO is non-empty. It pops both FIFOs and writes the unmasked bytes into RAM that cycle. If the wdf FIFO is empty, the head stalls; later reads wait behind it.
  - Read at head: retires immediately. The RAM word is captured and enters a RD_LATENCY-deep valid/data shift pipeline.
  - The pipeline output drives app_rd_data, app_rd_data_valid and app_rd_data_end for exactly one cycle.
  - Read latency: acceptance into an empty FIFO gives valid exactly RD_LATENCY+1 cycles after the app_en&app_rdy edge.
  - There is no read-data backpressure, per the MIG interface.
- Read-after-write to the same word returns the new data; this follows from in-order retirement.
- Any other app_cmd value is accepted, retired without effect, and sets err_flag.
- app_wdf_wren=1 with app_wdf_end=0 on an accepted beat: the beat is still stored and err_flag is set.
- app_rd_data holds its last value when valid=0.
- Backpressure (BP_EN=1):
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle after calibration.
  - bp = (lfsr[1:0]==2'b00). With BP_EN=0, bp = 0.
- Simultaneous events: a push and a pop on a full FIFO in the same cycle is not allowed. Ready is computed from the pre-pop count, so a full FIFO deasserts ready even if it pops that cycle.
- Reset mid-operation discards queued commands, queued data and in-flight reads. No valid pulse is produced after reset assertion.

Test Plan:
1. Reset, CALIB_CYCLES=64 -> init_calib_complete=0, app_rdy=0 for 64 cycles. Both go to 1 at cycle 65. All outputs are 0 during reset.
2. Write 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 to addr 0x000_0008, then read addr 0x000_0008 -> one valid pulse with that data and app_rd_data_end=1. Valid arrives RD_LATENCY+1 cycles after the read handshake.
3. Present 3 wdf beats before any command, then 3 writes to addrs 0x10/0x18/0x20 and 3 reads of them -> data returns in order. app_wdf_rdy stays 1 until the 4th beat is pending.
4. Hold a write command with no data, then issue 4 reads -> app_rdy=0 after the FIFO fills and no rd_valid occurs. Once data arrives, the reads drain in order with the written value first.
5. Write all-ones, then write 0 with mask 16'hFFFE to the same address, then read -> 128'hFFFF…FF00.
6. app_cmd=3'b111 accepted -> err_flag=1 and it stays set. BP_EN=1 with ddr_rw TEST_LENGTH=10 -> 10 reads match and error_flag=0. Assert reset mid-burst -> no further rd_valid.
